decode_issue: RTL and testbench

- Instruction sequencer that drives the execution unit's command side.
- Fetches 16-bit words from a synchronous instruction ROM and decodes opcode, destination and operand register addresses.
- Issues each instruction to the EU as a one-cycle valid pulse.
- Holds a per-register scoreboard, cleared by EU writebacks, and stalls issue on RAW/WAW hazards.

---
 rtl/decode_issue.sv | 169 ++++++++++++++++
 tb/tb_decode_issue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// decode_issue: instruction sequencer for the execution unit's command side.
// Fetches 16-bit words from a synchronous ROM, decodes them, and issues each
// instruction as a one-cycle valid pulse. A per-register scoreboard tracks
// outstanding writes and stalls issue on RAW/WAW hazards. EU writebacks clear it.
module decode_issue #(
    parameter int                   PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    input  logic                eu_ready,
    input  logic                wb_en,
    input  logic [2:0]          wb_reg,
    output logic [3:0]          opcode,
    output logic [2:0]          op_a_adr,
    output logic [2:0]          op_b_adr,
    output logic [2:0]          dest_reg,
    output logic                issue_valid,
    output logic [7:0]          pending,
    output logic                halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          pend_q, pend_d;
    logic [3:0]          op_q, op_d;
    logic [2:0]          dst_q, dst_d;
    logic [2:0]          sra_q, sra_d;
    logic [2:0]          srb_q, srb_d;

    logic [7:0]          clr_mask;
    logic [7:0]          eff;
    logic [7:0]          set_mask;
    logic                hazard;
    logic                fire;

    // Low instruction bits carry no meaning in this encoding.
    logic                unused_low_bits;
    assign unused_low_bits = ^imem_data[2:0];

    // JMP target sits in the low byte; resize it to the PC width.
    function automatic logic [PC_WIDTH-1:0] jmp_target(input logic [15:0] w);
        return PC_WIDTH'(w[7:0]);
    endfunction

    // Everything except NOP/JMP/HALT/STORE writes its destination register.
    function automatic logic writes_dest(input logic [3:0] op);
        return !(op == OP_NOP || op == OP_JMP || op == OP_HALT || op == OP_STORE);
    endfunction

    // Next-state, hazard detection and scoreboard update.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        op_d     = op_q;
        dst_d    = dst_q;
        sra_d    = sra_q;
        srb_d    = srb_q;
        fire     = 1'b0;
        set_mask = 8'h00;

        // A writeback this cycle already counts as retired, so it can
        // unblock a waiting instruction without a bubble.
        clr_mask = wb_en ? (8'b1 << wb_reg) : 8'h00;
        eff      = pend_q & ~clr_mask;
        hazard   = eff[sra_q] | eff[srb_q] | (writes_dest(op_q) & eff[dst_q]);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d  = imem_data[15:12];
                dst_d = imem_data[11:9];
                sra_d = imem_data[8:6];
                srb_d = imem_data[5:3];
                case (imem_data[15:12])
                    OP_JMP: begin
                        pc_d    = jmp_target(imem_data);
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        state_d = S_HALTED;
                    end
                    OP_NOP: begin
                        pc_d    = pc_q + PC_WIDTH'(1);
                        state_d = S_FETCH;
                    end
                    default: begin
                        state_d = S_ISSUE;
                    end
                endcase
            end
            S_ISSUE: begin
                if (!hazard && eu_ready) begin
                    fire = 1'b1;
                    if (writes_dest(op_q)) begin
                        set_mask = 8'b1 << dst_q;
                    end
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            S_HALTED: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Set after clear: a same-cycle set of the same bit wins.
        pend_d = eff | set_mask;
    end

    // State, PC, scoreboard and issue-field registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= 8'h00;
            op_q    <= 4'h0;
            dst_q   <= 3'h0;
            sra_q   <= 3'h0;
            srb_q   <= 3'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            sra_q   <= sra_d;
            srb_q   <= srb_d;
        end
    end

    assign imem_addr   = pc_q;
    assign opcode      = op_q;
    assign dest_reg    = dst_q;
    assign op_a_adr    = sra_q;
    assign op_b_adr    = srb_q;
    assign pending     = pend_q;
    assign issue_valid = fire;
    assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_decode_issue.sv
// Testbench for decode_issue: random programs and EU behaviour checked against
// an instruction-level reference model, plus directed scenarios with literal values.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        reset, start, eu_ready, wb_en;
    logic [2:0]  wb_reg;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [3:0]  opcode;
    logic [2:0]  op_a_adr, op_b_adr, dest_reg;
    logic        issue_valid, halted;
    logic [7:0]  pending;

    logic [15:0] rom [256];

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    decode_issue #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .eu_ready(eu_ready), .wb_en(wb_en), .wb_reg(wb_reg),
        .opcode(opcode), .op_a_adr(op_a_adr), .op_b_adr(op_b_adr),
        .dest_reg(dest_reg), .issue_valid(issue_valid),
        .pending(pending), .halted(halted)
    );

    // Synchronous instruction ROM: data appears one cycle after the address.
    always @(posedge clk) imem_data <= rom[imem_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Phases of an instruction's life: waiting, address out, word back, waiting for EU, stopped.
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_ISSUE = 3, P_HALTED = 4;

    int       m_ph;
    bit [7:0] m_pc, m_pend;
    bit [3:0] m_op;
    bit [2:0] m_d, m_a, m_b;

    function automatic bit is_writer(input bit [3:0] op);
        return !(op == 4'd0 || op == 4'd5 || op == 4'd14 || op == 4'd15);
    endfunction

    always @(negedge clk) begin
        bit [7:0]  outstanding;
        bit        blocked, go;
        bit [15:0] w;
        #2;
        if (!reset || !chk_en) begin
            m_ph = P_IDLE; m_pc = 8'h00; m_pend = 8'h00;
            m_op = 4'h0; m_d = 3'h0; m_a = 3'h0; m_b = 3'h0;
        end
        if (chk_en) begin
            // Registers still owed to the EU once this cycle's writeback lands.
            outstanding = m_pend;
            if (wb_en) outstanding[wb_reg] = 1'b0;
            blocked = outstanding[m_a] || outstanding[m_b] || (is_writer(m_op) && outstanding[m_d]);
            go      = reset && (m_ph == P_ISSUE) && eu_ready && !blocked;

            chk("m_imem_addr",   imem_addr,   m_pc);
            chk("m_issue_valid", issue_valid, go);
            chk("m_halted",      halted,      m_ph == P_HALTED);
            chk("m_pending",     pending,     m_pend);
            chk("m_opcode",      opcode,      m_op);
            chk("m_dest_reg",    dest_reg,    m_d);
            chk("m_op_a_adr",    op_a_adr,    m_a);
            chk("m_op_b_adr",    op_b_adr,    m_b);

            if (reset) begin
                m_pend = outstanding;
                if (go && is_writer(m_op)) m_pend[m_d] = 1'b1;
                case (m_ph)
                    P_IDLE:   if (start) begin m_pc = 8'h00; m_ph = P_FETCH; end
                    P_FETCH:  m_ph = P_DECODE;
                    P_DECODE: begin
                        w    = rom[m_pc];
                        m_op = w[15:12]; m_d = w[11:9]; m_a = w[8:6]; m_b = w[5:3];
                        if (m_op == 4'd14)      begin m_pc = w[7:0]; m_ph = P_FETCH; end
                        else if (m_op == 4'd15) m_ph = P_HALTED;
                        else if (m_op == 4'd0)  begin m_pc = m_pc + 8'd1; m_ph = P_FETCH; end
                        else                    m_ph = P_ISSUE;
                    end
                    P_ISSUE:  if (go) begin m_pc = m_pc + 8'd1; m_ph = P_FETCH; end
                    default:  if (start) begin m_pc = 8'h00; m_ph = P_FETCH; end
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; wb_en = 1'b0; wb_reg = 3'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Start pulse at cycle 0; caller then steps cycle by cycle.
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    int          first_issue, first_halt, n_issue;
    logic [3:0]  cap_op;
    logic [2:0]  cap_d, cap_a, cap_b;
    logic [15:0] rw;

    initial begin
        reset = 1'b0; start = 1'b0; eu_ready = 1'b1; wb_en = 1'b0; wb_reg = 3'd0;
        clear_rom();
        @(posedge clk); @(posedge clk);
        chk_en = 1'b1;
        #1;
        chk("rst_pending",   pending,     8'h00);
        chk("rst_issue",     issue_valid, 1'b0);
        chk("rst_imem_addr", imem_addr,   8'h00);
        chk("rst_halted",    halted,      1'b0);
        chk("rst_opcode",    opcode,      4'h0);

        // Single writer then HALT.
        clear_rom(); rom[0] = 16'h1440; rom[1] = 16'hF000; eu_ready = 1'b1;
        do_reset(); kick();
        first_issue = -1; first_halt = -1;
        cap_op = '0; cap_d = '0; cap_a = '0; cap_b = '0;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            if (issue_valid && first_issue < 0) begin
                first_issue = c; cap_op = opcode; cap_d = dest_reg; cap_a = op_a_adr; cap_b = op_b_adr;
            end
            if (halted && first_halt < 0) first_halt = c;
        end
        chk("A_issue_cycle", first_issue, 3);
        chk("A_opcode",      cap_op, 4'd1);
        chk("A_dest",        cap_d,  3'd2);
        chk("A_op_a",        cap_a,  3'd1);
        chk("A_op_b",        cap_b,  3'd0);
        chk("A_halt_cycle",  first_halt, 6);
        chk("A_pending",     pending, 8'h04);

        // RAW stall released by a same-cycle writeback.
        clear_rom(); rom[0] = 16'h1440; rom[1] = 16'h1680;
        do_reset(); kick();
        n_issue = 0;
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            if (issue_valid) n_issue++;
        end
        chk("B_stalled_issues", n_issue, 1);
        @(negedge clk); wb_en = 1'b1; wb_reg = 3'd2; #1;
        chk("B_wb_issue", issue_valid, 1'b1);
        chk("B_dest",     dest_reg,    3'd3);
        chk("B_op_a",     op_a_adr,    3'd2);
        @(negedge clk); wb_en = 1'b0; #1;
        chk("B_pending",  pending,     8'h08);

        // EU not ready for four cycles in ISSUE.
        clear_rom(); rom[0] = 16'h1440; rom[1] = 16'hF000; eu_ready = 1'b0;
        do_reset(); kick();
        n_issue = 0;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (issue_valid) n_issue++;
        end
        chk("C_no_issue", n_issue, 0);
        chk("C_held_op",  opcode,   4'd1);
        chk("C_held_dst", dest_reg, 3'd2);
        @(negedge clk); eu_ready = 1'b1; #1;
        chk("C_issue",    issue_valid, 1'b1);
        next_cycle();
        chk("C_one_pulse", issue_valid, 1'b0);

        // STORE leaves the scoreboard alone; JMP redirects the fetch.
        clear_rom(); rom[0] = 16'h5048; rom[1] = 16'hE005;
        do_reset(); kick();
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            if (c == 3) begin
                chk("D_issue",   issue_valid, 1'b1);
                chk("D_opcode",  opcode,      4'd5);
                chk("D_op_a",    op_a_adr,    3'd1);
                chk("D_op_b",    op_b_adr,    3'd1);
            end
            if (c == 6) begin
                chk("D_jmp_addr", imem_addr, 8'h05);
                chk("D_pending",  pending,   8'h00);
            end
        end

        // PC wrap via NOP at the top address.
        clear_rom(); rom[0] = 16'hE0FF; rom[255] = 16'h0000;
        do_reset(); kick();
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            if (c == 3) chk("E_addr_ff",   imem_addr, 8'hFF);
            if (c == 5) chk("E_addr_wrap", imem_addr, 8'h00);
        end

        // Reset in the middle of a stalled ISSUE.
        clear_rom(); rom[0] = 16'h1640; rom[1] = 16'h1440; rom[2] = 16'h1680;
        do_reset(); kick();
        for (int c = 1; c <= 10; c++) next_cycle();
        chk("F_pending_pre", pending, 8'h0C);
        @(negedge clk); reset = 1'b0; #1;
        chk("F_pending",   pending,     8'h00);
        chk("F_issue",     issue_valid, 1'b0);
        chk("F_imem_addr", imem_addr,   8'h00);
        chk("F_halted",    halted,      1'b0);
        @(negedge clk); reset = 1'b1;

        // Randomized programs and EU behaviour.
        for (int run = 0; run < 3; run++) begin
            @(negedge clk); reset = 1'b0; start = 1'b0; wb_en = 1'b0;
            for (int i = 0; i < 256; i++) begin
                rw = 16'($urandom);
                case ($urandom_range(0, 19))
                    0:       rw[15:12] = 4'hF;
                    1, 2:    rw = {4'hE, 4'h0, 8'($urandom_range(0, 40))};
                    3, 4:    rw[15:12] = 4'h0;
                    5:       rw[15:12] = 4'h5;
                    default: rw[15:12] = 4'($urandom_range(1, 13));
                endcase
                rom[i] = rw;
            end
            @(negedge clk); reset = 1'b1;
            for (int c = 0; c < 2500; c++) begin
                @(negedge clk);
                eu_ready = ($urandom_range(0, 3) != 0);
                wb_en    = ($urandom_range(0, 2) == 0);
                wb_reg   = 3'($urandom);
                start    = ($urandom_range(0, 29) == 0);
                reset    = ($urandom_range(0, 599) != 0);
            end
        end
        @(negedge clk); reset = 1'b1; start = 1'b0; wb_en = 1'b0;
        @(negedge clk); #3;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
